// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM states, B-operand shift codes
// and the opcodes understood by the downstream 16-bit ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SHL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Command/response bundle between a command issuer (master) and the sequencer (slave).
interface alu_operand_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              start;
  logic              busy;
  logic              done;
  logic [1:0]        op;
  logic [REG_AW-1:0] rn;
  logic [REG_AW-1:0] rm;
  logic [REG_AW-1:0] rd;
  logic [1:0]        shift;
  logic              use_imm;
  logic [DATA_W-1:0] imm;
  logic              wb_en;
  logic [DATA_W-1:0] result;
  logic [2:0]        status;

  modport master (
    output start, op, rn, rm, rd, shift, use_imm, imm, wb_en,
    input  busy, done, result, status
  );

  modport slave (
    input  start, op, rn, rm, rd, shift, use_imm, imm, wb_en,
    output busy, done, result, status
  );
endinterface

// File: rtl/regfile_8x16.sv
// Register file with one shared operand read port, one debug read port and one
// synchronous write port; all entries clear on reset.
module regfile_8x16 #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata    = regs[raddr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle feeder for the 16-bit ALU: reads Rn/Rm (or imm) into A/B, captures
// the ALU result into C and flags into status, then writes C back to Rd.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_operand_sequencer_if.slave  cmd,
  output logic [DATA_W-1:0]       alu_ain,
  output logic [DATA_W-1:0]       alu_bin,
  output logic [1:0]              alu_op,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic                    alu_z,
  input  logic                    alu_n,
  input  logic                    alu_v,
  input  logic [REG_AW-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  state_e            state_reg;
  alu_op_e           op_reg;
  shift_e            shift_reg;
  logic [REG_AW-1:0] rn_reg, rm_reg, rd_reg;
  logic              use_imm_reg, wb_en_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] a_reg, b_reg, c_reg;
  logic [2:0]        status_reg;
  logic              busy_reg, done_reg;

  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] b_shifted;
  logic              rf_we;

  // The single operand read port serves Rn in RDA and Rm in RDB.
  assign rf_raddr = (state_reg == RDA) ? rn_reg : rm_reg;
  assign rf_we    = (state_reg == WB) && wb_en_reg;

  regfile_8x16 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_reg),
    .wdata    (c_reg),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    b_shifted = rf_rdata;
    case (shift_reg)
      SH_SHL:  b_shifted = {rf_rdata[DATA_W-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, rf_rdata[DATA_W-1:1]};
      SH_ASR:  b_shifted = {rf_rdata[DATA_W-1], rf_rdata[DATA_W-1:1]};
      default: b_shifted = rf_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= OP_ADD;
      shift_reg   <= SH_NONE;
      rn_reg      <= '0;
      rm_reg      <= '0;
      rd_reg      <= '0;
      use_imm_reg <= 1'b0;
      wb_en_reg   <= 1'b0;
      imm_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      status_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd.start) begin
            op_reg      <= alu_op_e'(cmd.op);
            shift_reg   <= shift_e'(cmd.shift);
            rn_reg      <= cmd.rn;
            rm_reg      <= cmd.rm;
            rd_reg      <= cmd.rd;
            use_imm_reg <= cmd.use_imm;
            imm_reg     <= cmd.imm;
            wb_en_reg   <= cmd.wb_en;
            busy_reg    <= 1'b1;
            state_reg   <= RDA;
          end
        end
        RDA: begin
          a_reg     <= rf_rdata;
          state_reg <= RDB;
        end
        RDB: begin
          b_reg     <= use_imm_reg ? imm_reg : b_shifted;
          state_reg <= EXEC;
        end
        EXEC: begin
          c_reg <= alu_out;
          // Only subtract (compare) commands update the flags.
          if (op_reg == OP_SUB) status_reg <= {alu_z, alu_n, alu_v};
          done_reg  <= 1'b1;
          state_reg <= WB;
        end
        WB: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alu_ain    = a_reg;
  assign alu_bin    = b_reg;
  assign alu_op     = op_reg;
  assign cmd.result = c_reg;
  assign cmd.status = status_reg;
  assign cmd.busy   = busy_reg;
  assign cmd.done   = done_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural 16-bit ALU attached.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic        alu_z, alu_n, alu_v;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  stat;
    logic [2:0]  rd;
    logic        wb;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mregs [8];
  logic [2:0]  mstat;

  alu_operand_sequencer_if #(.DATA_W(16), .REG_AW(3)) cmd ();

  alu_operand_sequencer #(.DATA_W(16), .NREGS(8), .REG_AW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd),
    .alu_ain  (alu_ain),
    .alu_bin  (alu_bin),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_z    (alu_z),
    .alu_n    (alu_n),
    .alu_v    (alu_v),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #10 clk = ~clk;

  // Returns {Z,N,V,out}.
  function automatic logic [18:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] o;
    logic        v;
    v = 1'b0;
    case (op)
      2'b00: begin o = a + b; v = (a[15] == b[15]) && (o[15] != a[15]); end
      2'b01: begin o = a - b; v = (a[15] != b[15]) && (o[15] != a[15]); end
      2'b10: o = a & b;
      default: o = ~b;
    endcase
    return {(o == 16'h0), o[15], v, o};
  endfunction

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] sh);
    case (sh)
      2'b01:   return {x[14:0], 1'b0};
      2'b10:   return {1'b0, x[15:1]};
      2'b11:   return {x[15], x[15:1]};
      default: return x;
    endcase
  endfunction

  assign {alu_z, alu_n, alu_v, alu_out} = alu_f(alu_op, alu_ain, alu_bin);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                       input logic [2:0] rd, input logic [1:0] sh, input logic ui,
                       input logic [15:0] imm, input logic wb);
    logic [15:0] b;
    logic [18:0] r;
    exp_t        e;
    b = ui ? imm : shf(mregs[rm], sh);
    r = alu_f(op, mregs[rn], b);
    if (op == 2'b01) mstat = r[18:16];
    e.res = r[15:0]; e.stat = mstat; e.rd = rd; e.wb = wb;
    sbq.push_back(e);
    @(negedge clk);
    cmd.op = op; cmd.rn = rn; cmd.rm = rm; cmd.rd = rd; cmd.shift = sh;
    cmd.use_imm = ui; cmd.imm = imm; cmd.wb_en = wb; cmd.start = 1'b1;
    @(negedge clk);
    cmd.start = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), {16'h0, dbg_data}, {16'h0, mregs[i]});
    end
  endtask

  task automatic wait_done(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!cmd.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3);
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_result"}, {16'h0, cmd.result}, {16'h0, e.res});
    check({tag, "_status"}, {29'h0, cmd.status}, {29'h0, e.stat});
    check({tag, "_busy_wb"}, {31'h0, cmd.busy}, 1);
    $display("[TB] %s: rd=%0d wb=%0d result=%h status=%b", tag, e.rd, e.wb, cmd.result, cmd.status);
    if (e.wb) mregs[e.rd] = e.res;
    @(negedge clk);
    cmd.start = 1'b0;
    check({tag, "_done_low"}, {31'h0, cmd.done}, 0);
    check({tag, "_busy_low"}, {31'h0, cmd.busy}, 0);
    check_regs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    reset = 1'b1;
    cmd.start = 1'b0; cmd.op = '0; cmd.rn = '0; cmd.rm = '0; cmd.rd = '0;
    cmd.shift = '0; cmd.use_imm = 1'b0; cmd.imm = '0; cmd.wb_en = 1'b0;
    dbg_addr = '0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mstat = '0;
    #5;
    check("rst_busy",   {31'h0, cmd.busy}, 0);
    check("rst_done",   {31'h0, cmd.done}, 0);
    check("rst_result", {16'h0, cmd.result}, 0);
    check("rst_status", {29'h0, cmd.status}, 0);
    check("rst_ain",    {16'h0, alu_ain}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: R1 = R1 + 7
    issue(2'b00, 3'd1, 3'd1, 3'd1, 2'b00, 1'b1, 16'h0007, 1'b1);
    wait_done("t1");
    check("t1_R1", {16'h0, mregs[1]}, 32'h7);

    // 2: R4 = R2 - (R3 << 1) with R2=5, R3=3
    issue(2'b00, 3'd0, 3'd0, 3'd2, 2'b00, 1'b1, 16'd5, 1'b1); wait_done("t2_ld2");
    issue(2'b00, 3'd0, 3'd0, 3'd3, 2'b00, 1'b1, 16'd3, 1'b1); wait_done("t2_ld3");
    issue(2'b01, 3'd2, 3'd3, 3'd4, 2'b01, 1'b0, 16'h0, 1'b1); wait_done("t2");
    check("t2_status_spec", {29'h0, cmd.status}, 32'b010);
    check("t2_R4_spec", {16'h0, mregs[4]}, 32'hFFFF);

    // 3: compare 0x8000 - 1, no writeback
    issue(2'b00, 3'd0, 3'd0, 3'd5, 2'b00, 1'b1, 16'h8000, 1'b1); wait_done("t3_ld5");
    issue(2'b01, 3'd5, 3'd0, 3'd6, 2'b00, 1'b1, 16'd1, 1'b0);    wait_done("t3");
    check("t3_status_spec", {29'h0, cmd.status}, 32'b001);

    // 4: not-B of asr1(0x8002)
    issue(2'b00, 3'd0, 3'd0, 3'd6, 2'b00, 1'b1, 16'h8002, 1'b1); wait_done("t4_ld6");
    issue(2'b11, 3'd0, 3'd6, 3'd7, 2'b11, 1'b0, 16'h0, 1'b1);    wait_done("t4");
    check("t4_bin",    {16'h0, alu_bin}, 32'hC001);
    check("t4_result", {16'h0, cmd.result}, 32'h3FFE);
    check("t4_status_hold", {29'h0, cmd.status}, 32'b001);

    // 5a: start held high while busy (with different fields) is ignored
    issue(2'b00, 3'd0, 3'd0, 3'd2, 2'b00, 1'b1, 16'h0011, 1'b1);
    cmd.start = 1'b1; cmd.rd = 3'd1; cmd.imm = 16'hDEAD;
    wait_done("t5_busy");
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmd.done) ndone++;
    end
    check("t5_extra_done", ndone, 0);
    check_regs("t5_after");

    // 5b: reset in EXEC aborts the command
    issue(2'b00, 3'd1, 3'd1, 3'd3, 2'b00, 1'b1, 16'h0005, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    void'(sbq.pop_back());
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mstat = '0;
    check("t5_rst_busy",   {31'h0, cmd.busy}, 0);
    check("t5_rst_done",   {31'h0, cmd.done}, 0);
    check("t5_rst_result", {16'h0, cmd.result}, 0);
    check("t5_rst_status", {29'h0, cmd.status}, 0);
    check("t5_rst_ain",    {16'h0, alu_ain}, 0);
    check("t5_rst_bin",    {16'h0, alu_bin}, 0);
    check_regs("t5_rst");
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmd.done) ndone++;
    end
    check("t5_rst_no_done", ndone, 0);
    $display("[TB] t5_rst: command aborted by reset in EXEC");

    // 6: equal operands via sub
    issue(2'b00, 3'd0, 3'd0, 3'd4, 2'b00, 1'b1, 16'h1234, 1'b1); wait_done("t6_ld4");
    issue(2'b01, 3'd4, 3'd4, 3'd5, 2'b00, 1'b0, 16'h0, 1'b1);    wait_done("t6");
    check("t6_result_spec", {16'h0, cmd.result}, 32'h0);
    check("t6_status_spec", {29'h0, cmd.status}, 32'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
